text_screen_buffer: RTL

Parametrised text-mode screen buffer for the VGA pipeline. It converts the raster counters into a character-cell address and returns the stored character code. It also returns the glyph row and column inside the cell, so the font ROM can look up the pixel.
- Display reads run on a 2-stage registered pipeline.
- A request/acknowledge write port updates cells only during blanking.
- Sits between the timing generator and the font ROM / pixel mux.

---
 rtl/vga_text_pkg.sv | 15 +
 rtl/text_cell_ram.sv | 30 +++
 rtl/text_screen_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared geometry defaults and the cell-address type for the VGA text-mode path.
package vga_text_pkg;

    localparam int COLS     = 80;
    localparam int ROWS     = 40;
    localparam int CELL_W   = 8;
    localparam int CELL_H   = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 12;

    typedef logic [ADDR_W-1:0] cell_addr_t;

endpackage

// File: rtl/text_cell_ram.sv
// Single-port synchronous character RAM: one access per cycle, registered read data.
module text_cell_ram
    import vga_text_pkg::*;
#(
    parameter int DEPTH  = vga_text_pkg::COLS * vga_text_pkg::ROWS,
    parameter int DATA_W = vga_text_pkg::DATA_W,
    parameter int ADDR_W = vga_text_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Addresses past the end (blanking columns) read as zero; the result is discarded anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if ({1'b0, addr} < (ADDR_W+1)'(DEPTH)) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/text_screen_buffer.sv
// Text-mode screen buffer: raster -> cell address -> character code, 2-cycle read pipeline.
// Optional cursor blink logic is enabled with the TEXT_SCREEN_CURSOR_EN macro.
module text_screen_buffer
    import vga_text_pkg::*;
#(
    parameter int COLS         = vga_text_pkg::COLS,
    parameter int ROWS         = vga_text_pkg::ROWS,
    parameter int CELL_W       = vga_text_pkg::CELL_W,
    parameter int CELL_H       = vga_text_pkg::CELL_H,
    parameter int H_ACTIVE     = vga_text_pkg::H_ACTIVE,
    parameter int V_ACTIVE     = vga_text_pkg::V_ACTIVE,
    parameter int DATA_W       = vga_text_pkg::DATA_W,
    parameter int ADDR_W       = vga_text_pkg::ADDR_W,
    parameter int BLINK_FRAMES = 30,
    localparam int GR_W = (CELL_H > 1) ? $clog2(CELL_H) : 1,
    localparam int GC_W = (CELL_W > 1) ? $clog2(CELL_W) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        HorizontalCounter,
    input  logic [9:0]        VerticalCounter,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic [ADDR_W-1:0] cursor_addr,
    output logic [DATA_W-1:0] char,
    output logic [GR_W-1:0]   glyph_row,
    output logic [GC_W-1:0]   glyph_col,
    output logic              active_out,
    output logic              cursor_hit
);

    localparam int DEPTH     = COLS * ROWS;
    localparam int COL_SHIFT = $clog2(CELL_W);

    logic              frame_start;
    logic              line_end;
    logic              active;
    logic [9:0]        col;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_eff;
    logic [GR_W-1:0]   sub_row;
    logic [GR_W-1:0]   sub_row_eff;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              write_ok;
    logic              in_range;
    logic              ram_we;

    logic [ADDR_W-1:0] s1_addr;
    logic [GR_W-1:0]   s1_row;
    logic [GC_W-1:0]   s1_col;
    logic              s1_active;
    logic [ADDR_W-1:0] s2_addr;

    assign frame_start = (HorizontalCounter == 10'd0) && (VerticalCounter == 10'd0);
    assign active      = (HorizontalCounter < 10'(H_ACTIVE)) && (VerticalCounter < 10'(V_ACTIVE));
    assign line_end    = (HorizontalCounter == 10'(H_ACTIVE - 1)) && (VerticalCounter < 10'(V_ACTIVE));

    // The (0,0) pixel must already see row 0, before the register has caught up.
    assign row_base_eff = frame_start ? '0 : row_base;
    assign sub_row_eff  = frame_start ? '0 : sub_row;
    assign col          = HorizontalCounter >> COL_SHIFT;
    assign rd_addr      = row_base_eff + ADDR_W'(col);

    always_ff @(posedge clk) begin
        if (reset) begin
            row_base <= '0;
            sub_row  <= '0;
        end else if (frame_start) begin
            row_base <= '0;
            sub_row  <= '0;
        end else if (line_end) begin
            if (sub_row == GR_W'(CELL_H - 1)) begin
                sub_row  <= '0;
                row_base <= row_base + ADDR_W'(COLS);
            end else begin
                sub_row  <= sub_row + GR_W'(1);
            end
        end
    end

    // Writes only land while the raster is blank, so they never collide with a display read.
    assign in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
    assign write_ok = wr_req & ~active & ~reset;
    assign wr_ack   = write_ok;
    assign wr_err   = write_ok & ~in_range;
    assign ram_we   = write_ok & in_range;
    assign ram_addr = ram_we ? wr_addr : rd_addr;

    text_cell_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_addr    <= '0;
            s1_row     <= '0;
            s1_col     <= '0;
            s1_active  <= 1'b0;
            s2_addr    <= '0;
            char       <= '0;
            glyph_row  <= '0;
            glyph_col  <= '0;
            active_out <= 1'b0;
        end else begin
            s1_addr    <= rd_addr;
            s1_row     <= sub_row_eff;
            s1_col     <= GC_W'(HorizontalCounter & 10'(CELL_W - 1));
            s1_active  <= active;
            s2_addr    <= s1_addr;
            char       <= s1_active ? ram_rdata : '0;
            glyph_row  <= s1_active ? s1_row : '0;
            glyph_col  <= s1_active ? s1_col : '0;
            active_out <= s1_active;
        end
    end

`ifdef TEXT_SCREEN_CURSOR_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);

    logic [FC_W-1:0] frame_cnt;
    logic            phase;

    // frame_cnt counts (0,0) points since the last toggle; phase flips on the one after BLINK_FRAMES.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES)) begin
                frame_cnt <= FC_W'(1);
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    assign cursor_hit = active_out & phase & (s2_addr == cursor_addr);
`else
    logic unused_cursor;

    assign unused_cursor = ^{cursor_addr, s2_addr, (BLINK_FRAMES > 0)};
    assign cursor_hit    = 1'b0;
`endif

endmodule
